multi_edge_detect: RTL
======================

// Module: multi_edge_detect
// PURPOSE
//  Parametrised multi-channel edge detector: synchronises WIDTH async inputs, then emits
//  one-cycle pulses on rising, falling or both edges (run-time mode), with per-channel
//  sticky flags and saturating edge counters. Sits at the boundary between external or
//  slow-domain signals and clk-domain control/status logic.
// PARAMETERS
//  WIDTH        4   number of independent input channels (>=1)
//  SYNC_STAGES  2   synchroniser flops per channel (>=2)
//  CNT_W        8   width of each per-channel edge counter (>=1)
// PORTS
//  clk      in   1            system clock; all logic on posedge
//  rst      in   1            synchronous, active-high reset
//  din      in   WIDTH        asynchronous level inputs, one bit per channel
//  mode     in   2            00 rising, 01 falling, 10 both, 11 detection disabled
//  clr      in   WIDTH        per-channel clear of sticky and cnt (clk-domain)
//  pulse    out  WIDTH        one-cycle edge pulse per channel (registered)
//  sticky   out  WIDTH        per-channel flag: set by pulse, cleared by clr/rst
//  cnt      out  WIDTH*CNT_W  packed counters; channel i at [i*CNT_W +: CNT_W]
//  any_edge out  1            OR of all pulse bits, same cycle as pulse
// BEHAVIOUR
//  - Reset (rst=1 at posedge): all sync flops, prev flops, pulse, sticky, cnt, warm-up
//    counter and armed flag -> 0. any_edge=0. Reset mid-operation aborts in-flight pulses.
//  - Pipeline per channel: s[0]<=din; s[k]<=s[k-1]; prev<=s[S-1] (S=SYNC_STAGES).
//  - Edge terms: rise = s[S-1]&~prev; fall = ~s[S-1]&prev; sel by mode (both = rise|fall;
//    11 -> 0). pulse <= sel & armed.
//  - Latency: din settles before posedge E0 -> pulse high for exactly the cycle after posedge
//    E0+S. Each edge gives exactly one pulse; a level held any length gives no further pulses.
//  - Input pulses narrower than one clk period may be missed; not a requirement to catch them.
//  - Warm-up: after rst deasserts, a counter runs S+1 clocks; armed=1 at the (S+1)th posedge
//    with rst low. Before armed, pipeline/prev track din but pulse stays 0 (no false edge from
//    a din held high through reset).
//  - mode is sampled at the same posedge as pulse is registered; change takes effect for the
//    next pulse decision, no re-arm needed. mode=11 freezes sticky/cnt (no pulses).
//  - sticky[i]/cnt[i] update at the same posedge pulse[i] is registered (visible with pulse).
//  - cnt[i] saturates at 2^CNT_W-1; further edges keep sticky=1, cnt unchanged.
//  - clr[i] at a posedge: sticky[i]<=0, cnt[i]<=0; clr has priority over a simultaneous edge
//    for sticky/cnt (edge not counted), but pulse[i] still fires. clr does not affect other
//    channels or the sync pipeline.
//  - Channels fully independent; simultaneous edges on several channels all pulse same cycle.
// TESTING
//  1 Reset with din=4'b1111 held, rst low 10 cycles -> pulse never asserts, cnt all 0,
//    sticky 0; armed at 3rd posedge after release (S=2).
//  2 mode=00, din[0] 0->1 before posedge E0 -> pulse[0]=1 only in cycle after E0+2,
//    any_edge=1 same cycle, sticky[0]=1, cnt[0]=1; 1->0 later -> no pulse.
//  3 mode=10, din[2] toggled 5 times, 6 cycles apart -> 5 single pulses on pulse[2],
//    cnt[2]=5; mode=01 same stimulus -> 2 or 3 pulses (falling only) matching edges.
//  4 CNT_W=3, 10 rising edges on ch1 -> cnt[1] stops at 7, sticky[1]=1.
//  5 clr[3] asserted in same cycle pulse[3] registers -> pulse[3]=1, cnt[3]=0, sticky[3]=0;
//    other channels' counts unchanged.
//  6 rst pulsed 1 cycle while an edge is inside the sync pipeline -> no pulse, all outputs 0,
//    warm-up restarts; mode=11 with edges on all channels -> pulse/sticky/cnt stay 0.

Source files
------------

// File: rtl/multi_edge_detect.sv
// Multi-channel edge detector.
// Each asynchronous input channel passes through a synchroniser chain and then a
// "previous value" flop. Edge terms are formed between the two, filtered by the
// run-time mode, and gated by a warm-up flag. The result is registered as a
// one-cycle pulse. A per-channel sticky flag and a saturating edge counter update
// on the same clock edge as the pulse.
module multi_edge_detect #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       din,
    input  logic [1:0]             mode,
    input  logic [WIDTH-1:0]       clr,
    output logic [WIDTH-1:0]       pulse,
    output logic [WIDTH-1:0]       sticky,
    output logic [WIDTH*CNT_W-1:0] cnt,
    output logic                   any_edge
);

    typedef enum logic [1:0] {
        MODE_RISE = 2'b00,
        MODE_FALL = 2'b01,
        MODE_BOTH = 2'b10,
        MODE_OFF  = 2'b11
    } mode_e;

    // The warm-up counter counts 0..SYNC_STAGES. Detection is armed on the clock
    // after it reaches SYNC_STAGES, which is the (SYNC_STAGES+1)th clock out of reset.
    localparam int                 WARM_W    = $clog2(SYNC_STAGES + 1);
    localparam logic [WARM_W-1:0]  WARM_LAST = WARM_W'(SYNC_STAGES);
    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

    logic [WIDTH-1:0]       sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]       prev_q;
    logic [WARM_W-1:0]      warm_q, warm_d;
    logic                   armed_q, armed_d;
    logic [WIDTH-1:0]       pulse_q, pulse_d;
    logic [WIDTH-1:0]       sticky_q, sticky_d;
    logic [WIDTH*CNT_W-1:0] cnt_q, cnt_d;
    logic                   any_q, any_d;
    logic [WIDTH-1:0]       rise_s, fall_s, sel_s;

    // Synchroniser chain and previous-value flop. These run even while not yet armed.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= din;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Warm-up sequencing: count clocks out of reset, then arm detection permanently.
    always_comb begin
        warm_d  = warm_q;
        armed_d = armed_q;
        if (!armed_q) begin
            if (warm_q == WARM_LAST) begin
                armed_d = 1'b1;
            end else begin
                warm_d = warm_q + 1'b1;
            end
        end else begin
            warm_d = warm_q;
        end
    end

    // Edge terms, mode selection and warm-up gating for the next pulse value.
    always_comb begin
        rise_s = sync_q[SYNC_STAGES-1] & ~prev_q;
        fall_s = ~sync_q[SYNC_STAGES-1] & prev_q;
        case (mode_e'(mode))
            MODE_RISE: sel_s = rise_s;
            MODE_FALL: sel_s = fall_s;
            MODE_BOTH: sel_s = rise_s | fall_s;
            MODE_OFF:  sel_s = '0;
            default:   sel_s = '0;
        endcase
        if (armed_q) begin
            pulse_d = sel_s;
        end else begin
            pulse_d = '0;
        end
        any_d = |pulse_d;
    end

    // Sticky flags and saturating counters. A clear wins over a simultaneous edge.
    always_comb begin
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (clr[i]) begin
                sticky_d[i]              = 1'b0;
                cnt_d[i*CNT_W +: CNT_W]  = '0;
            end else if (pulse_d[i]) begin
                sticky_d[i] = 1'b1;
                if (cnt_q[i*CNT_W +: CNT_W] != CNT_MAX) begin
                    cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + 1'b1;
                end else begin
                    cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W];
                end
            end else begin
                sticky_d[i]             = sticky_q[i];
                cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W];
            end
        end
    end

    // Registered state: warm-up, pulse, sticky, counters and the any-edge summary.
    always_ff @(posedge clk) begin
        if (rst) begin
            warm_q   <= '0;
            armed_q  <= 1'b0;
            pulse_q  <= '0;
            sticky_q <= '0;
            cnt_q    <= '0;
            any_q    <= 1'b0;
        end else begin
            warm_q   <= warm_d;
            armed_q  <= armed_d;
            pulse_q  <= pulse_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            any_q    <= any_d;
        end
    end

    assign pulse    = pulse_q;
    assign sticky   = sticky_q;
    assign cnt      = cnt_q;
    assign any_edge = any_q;

endmodule
